// File: rtl/frame_pkg.sv
// ---------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the framed byte-stream receiver:
//   - receiver state encoding (state_t)
//   - frame outcome codes reported on frame_err (frame_err_t)
//   - default two-byte sync header
// No ports; imported by frame_rx_check and crc16_d8.
// ---------------------------------------------------------------------------
package frame_pkg;

  localparam int          DATA_W            = 8;
  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hEB90;

  typedef enum logic [2:0] {
    HUNT0   = 3'd0,
    HUNT1   = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CRC_H   = 3'd4,
    CRC_L   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_CRC      = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ZERO_LEN = 2'b11
  } frame_err_t;

endpackage

// File: rtl/crc16_d8.sv
// ---------------------------------------------------------------------------
// crc16_d8
// Combinational CRC16 step over one byte, MSB first, no reflection.
// POLYNOMIAL is intended to be 16'h8005 or 16'h1021.
// Ports:
//   crc_in   [15:0] : current CRC register value
//   data     [7:0]  : byte folded in this step
//   crc_next [15:0] : CRC after the byte
// ---------------------------------------------------------------------------
module crc16_d8
  import frame_pkg::*;
#(
  parameter logic [15:0] POLYNOMIAL = 16'h8005
) (
  input  logic [15:0]       crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [15:0]       crc_next
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ POLYNOMIAL;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    crc_next = c;
  end

endmodule

// File: rtl/frame_rx_check.sv
// ---------------------------------------------------------------------------
// frame_rx_check
// Receives a byte stream, locks onto the SYNC_WORD header, reads a length
// byte, forwards LEN payload bytes and checks the trailing CRC16 (sent as
// the complement of the CRC over LEN + payload, high byte first).
// Optional feature macro: FRAME_RX_CHECK_STATS_EN adds ok_cnt / err_cnt.
// Ports:
//   clk_in, rst_n (async, active-low)
//   data_in[7:0], valid_in      : incoming bytes, one per valid cycle
//   pl_data[7:0], pl_valid      : forwarded payload, 1-cycle latency
//   pl_sof, pl_eof              : first / last payload byte markers
//   frame_done, frame_err[1:0]  : outcome pulse; 00 ok, 01 crc, 10 timeout,
//                                 11 zero length
//   ok_cnt, err_cnt [15:0]      : saturating outcome counters (stats build)
// ---------------------------------------------------------------------------
module frame_rx_check
  import frame_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
  parameter logic [15:0] POLYNOMIAL     = 16'h8005,
  parameter logic [15:0] INIT_VALUE     = 16'hFFFF,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] pl_data,
  output logic              pl_valid,
  output logic              pl_sof,
  output logic              pl_eof,
  output logic              frame_done,
  output logic [1:0]        frame_err
`ifdef FRAME_RX_CHECK_STATS_EN
  ,
  output logic [15:0]       ok_cnt,
  output logic [15:0]       err_cnt
`endif
);

  localparam int              IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [7:0]        len_cnt;
  logic [15:0]       crc_reg;
  logic [7:0]        crc_hi;
  logic              sof_pend;
  logic [IDLE_W-1:0] idle_cnt;

  logic [15:0]       crc_seed;
  logic [15:0]       crc_next;
  logic              timeout_hit;

  // The LEN byte restarts the CRC from the seed rather than crc_reg.
  assign crc_seed = (state == LEN) ? INIT_VALUE : crc_reg;

  crc16_d8 #(
    .POLYNOMIAL (POLYNOMIAL)
  ) u_crc (
    .crc_in   (crc_seed),
    .data     (data_in),
    .crc_next (crc_next)
  );

  // Fires on the idle cycle that makes the count reach TIMEOUT_CYCLES; a byte
  // in that same cycle wins because valid_in gates it.
  assign timeout_hit = (state != HUNT0) && !valid_in && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT0;
      len_cnt    <= '0;
      crc_reg    <= INIT_VALUE;
      crc_hi     <= '0;
      sof_pend   <= 1'b0;
      idle_cnt   <= '0;
      pl_data    <= '0;
      pl_valid   <= 1'b0;
      pl_sof     <= 1'b0;
      pl_eof     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= ERR_OK;
    end else begin
      pl_valid   <= 1'b0;
      pl_sof     <= 1'b0;
      pl_eof     <= 1'b0;
      frame_done <= 1'b0;

      if (valid_in || state == HUNT0) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (timeout_hit) begin
        state      <= HUNT0;
        idle_cnt   <= '0;
        frame_done <= 1'b1;
        frame_err  <= ERR_TIMEOUT;
      end else if (valid_in) begin
        case (state)
          HUNT0: begin
            if (data_in == SYNC_WORD[15:8]) state <= HUNT1;
          end
          HUNT1: begin
            // A repeated first sync byte may itself start the header.
            if (data_in == SYNC_WORD[7:0])       state <= LEN;
            else if (data_in == SYNC_WORD[15:8]) state <= HUNT1;
            else                                 state <= HUNT0;
          end
          LEN: begin
            crc_reg  <= crc_next;
            len_cnt  <= data_in;
            sof_pend <= 1'b1;
            if (data_in == 8'd0) begin
              state      <= HUNT0;
              frame_done <= 1'b1;
              frame_err  <= ERR_ZERO_LEN;
            end else begin
              state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            crc_reg  <= crc_next;
            pl_data  <= data_in;
            pl_valid <= 1'b1;
            pl_sof   <= sof_pend;
            sof_pend <= 1'b0;
            len_cnt  <= len_cnt - 8'd1;
            if (len_cnt == 8'd1) begin
              pl_eof <= 1'b1;
              state  <= CRC_H;
            end
          end
          CRC_H: begin
            crc_hi <= data_in;
            state  <= CRC_L;
          end
          CRC_L: begin
            frame_done <= 1'b1;
            frame_err  <= ({crc_hi, data_in} == ~crc_reg) ? ERR_OK : ERR_CRC;
            state      <= HUNT0;
          end
          default: state <= HUNT0;
        endcase
      end
    end
  end

`ifdef FRAME_RX_CHECK_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counters follow the registered outcome, one cycle behind frame_done.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else if (frame_done) begin
      if (frame_err == ERR_OK) ok_cnt  <= sat_inc(ok_cnt);
      else                     err_cnt <= sat_inc(err_cnt);
    end
  end
`endif

endmodule
